reg_bank_sb: RTL and testbench

//  Parametrised integer register file with scoreboard, successor to the single-issue bank.
//  NUM_RD read ports; any read port can select the PC instead of a register.
//  One writeback port. Per-register busy bits track writes that have issued but not yet written back.

---
 rtl/reg_bank_sb_pkg.sv | 14 +
 rtl/reg_bank_sb_if.sv | 32 +++
 rtl/reg_bank_sb_rdport.sv | 44 ++++
 rtl/reg_bank_sb.sv | 80 ++++++++
 tb/tb_reg_bank_sb.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/reg_bank_sb_pkg.sv
// Shared defaults and types for the scoreboarded register bank.
// Optional read bypass is enabled by defining REG_BANK_SB_BYPASS_EN.
package reg_bank_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREG_DEF   = 32;
    localparam int NUM_RD_DEF = 3;
    localparam int AW_DEF     = $clog2(NREG_DEF);
    localparam int SEL_PC_BIT = AW_DEF;

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xdata_t;

endpackage

// File: rtl/reg_bank_sb_if.sv
// Operand-read, issue and writeback signals between the pipeline and reg_bank_sb.
// master = pipeline side, slave = register bank.
interface reg_bank_sb_if #(
    parameter int XLEN   = reg_bank_pkg::XLEN_DEF,
    parameter int NREG   = reg_bank_pkg::NREG_DEF,
    parameter int NUM_RD = reg_bank_pkg::NUM_RD_DEF
);
    localparam int AW = $clog2(NREG);
    localparam int SW = AW + 1;

    logic [NUM_RD*SW-1:0]   rd_sel;
    logic [XLEN-1:0]        in_pc;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   iss_valid;
    logic [AW-1:0]          iss_rd;
    logic                   iss_ready;
    logic                   wb_valid;
    logic [AW-1:0]          wb_rd;
    logic [XLEN-1:0]        wb_data;
    logic [AW:0]            pend_cnt;

    modport master (
        output rd_sel, in_pc, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
        input  rd_data, rd_busy, iss_ready, pend_cnt
    );

    modport slave (
        input  rd_sel, in_pc, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
        output rd_data, rd_busy, iss_ready, pend_cnt
    );
endinterface

// File: rtl/reg_bank_sb_rdport.sv
// One combinational read port: PC select, x0 handling, optional writeback bypass
// (REG_BANK_SB_BYPASS_EN) and busy lookup.
module reg_bank_sb_rdport #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic [AW:0]     sel_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] bank_i [NREG],
    input  logic [NREG-1:0] busy_i,
`ifdef REG_BANK_SB_BYPASS_EN
    input  logic            wb_valid_i,
    input  logic [AW-1:0]   wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            iss_en_i,
    input  logic [AW-1:0]   iss_rd_i,
`endif
    output logic [XLEN-1:0] data_o,
    output logic            busy_o
);
    import reg_bank_pkg::*;

    logic [AW-1:0] idx;

    always_comb begin
        idx    = sel_i[AW-1:0];
        data_o = '0;
        busy_o = 1'b0;
        if (sel_i[AW]) begin
            data_o = pc_i;
        end else if (idx != '0) begin
            data_o = bank_i[idx];
            busy_o = busy_i[idx];
`ifdef REG_BANK_SB_BYPASS_EN
            // Retiring value is forwarded; it stays busy only if re-reserved this cycle.
            if (wb_valid_i && (wb_rd_i == idx)) begin
                data_o = wb_data_i;
                busy_o = iss_en_i && (iss_rd_i == idx);
            end
`endif
        end
    end
endmodule

// File: rtl/reg_bank_sb.sv
// Integer register file with per-register busy scoreboard and pending-write count.
// Define REG_BANK_SB_BYPASS_EN to forward writeback data to read ports in the same cycle.
module reg_bank_sb #(
    parameter int XLEN   = reg_bank_pkg::XLEN_DEF,
    parameter int NREG   = reg_bank_pkg::NREG_DEF,
    parameter int NUM_RD = reg_bank_pkg::NUM_RD_DEF
) (
    input logic          clk,
    input logic          reset,
    reg_bank_sb_if.slave bus
);
    import reg_bank_pkg::*;

    localparam int AW = $clog2(NREG);
    localparam int SW = AW + 1;

    logic [XLEN-1:0] bank_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [AW:0]     pend_q, pend_d;

    logic wb_en, iss_ready, iss_en, clr_en;

    assign wb_en     = bus.wb_valid && (bus.wb_rd != '0);
    assign iss_ready = bus.iss_valid &&
                       ((bus.iss_rd == '0) || !busy_q[bus.iss_rd] ||
                        (bus.wb_valid && (bus.wb_rd == bus.iss_rd)));
    assign iss_en    = iss_ready && (bus.iss_rd != '0);
    assign clr_en    = wb_en && busy_q[bus.wb_rd];

    // Same-rd wb+issue counts as one clear and one set, so the total stays a popcount.
    assign pend_d = pend_q + {{AW{1'b0}}, iss_en} - {{AW{1'b0}}, clr_en};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                bank_q[i] <= '0;
            end
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            if (wb_en) begin
                bank_q[bus.wb_rd] <= bus.wb_data;
                busy_q[bus.wb_rd] <= 1'b0;
            end
            if (iss_en) begin
                busy_q[bus.iss_rd] <= 1'b1;
            end
            pend_q <= pend_d;
        end
    end

    logic [NUM_RD*XLEN-1:0] rd_data_w;
    logic [NUM_RD-1:0]      rd_busy_w;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        reg_bank_sb_rdport #(
            .XLEN (XLEN),
            .NREG (NREG)
        ) u_rdport (
            .sel_i      (bus.rd_sel[p*SW +: SW]),
            .pc_i       (bus.in_pc),
            .bank_i     (bank_q),
            .busy_i     (busy_q),
`ifdef REG_BANK_SB_BYPASS_EN
            .wb_valid_i (bus.wb_valid),
            .wb_rd_i    (bus.wb_rd),
            .wb_data_i  (bus.wb_data),
            .iss_en_i   (iss_en),
            .iss_rd_i   (bus.iss_rd),
`endif
            .data_o     (rd_data_w[p*XLEN +: XLEN]),
            .busy_o     (rd_busy_w[p])
        );
    end

    assign bus.rd_data   = rd_data_w;
    assign bus.rd_busy   = rd_busy_w;
    assign bus.iss_ready = iss_ready;
    assign bus.pend_cnt  = pend_q;
endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed vector bench for reg_bank_sb; expectations follow REG_BANK_SB_BYPASS_EN.
module tb_reg_bank_sb;

`ifdef REG_BANK_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;

    reg_bank_sb_if #(.XLEN(32), .NREG(32), .NUM_RD(3)) bus ();

    reg_bank_sb #(.XLEN(32), .NREG(32), .NUM_RD(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic [5:0] s0, input logic [5:0] s1, input logic [5:0] s2,
                         input logic [31:0] pc, input logic iv, input logic [4:0] ir,
                         input logic wv, input logic [4:0] wr, input logic [31:0] wd);
        bus.rd_sel    = {s2, s1, s0};
        bus.in_pc     = pc;
        bus.iss_valid = iv;
        bus.iss_rd    = ir;
        bus.wb_valid  = wv;
        bus.wb_rd     = wr;
        bus.wb_data   = wd;
    endtask

    typedef struct {
        logic [5:0]  s0, s1, s2;
        logic [31:0] pc;
        logic        iv;
        logic [4:0]  ir;
        logic        wv;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] e0, e1, e2;
        logic [2:0]  eb;
        logic        er;
        logic [5:0]  ep;
    } vec_t;

    vec_t vt [12];

    initial begin
        // s0 s1 s2 pc | iv ir | wv wr wd | e0 e1 e2 | eb(b2b1b0) er ep
        vt[0]  = '{6'h23, 6'd0, 6'd0, 32'h100, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFF,
                   32'h100, 32'h0, 32'h0, 3'b000, 1'b0, 6'd0};
        vt[1]  = '{6'h23, 6'd0, 6'd0, 32'h200, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0,
                   32'h200, 32'h0, 32'h0, 3'b000, 1'b1, 6'd0};
        vt[2]  = '{6'd3, 6'd0, 6'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0,
                   32'h0, 32'h0, 32'h0, 3'b001, 1'b0, 6'd1};
        vt[3]  = '{6'd3, 6'd0, 6'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h55,
                   BYP ? 32'h55 : 32'h0, 32'h0, 32'h0, BYP ? 3'b000 : 3'b001, 1'b0, 6'd1};
        vt[4]  = '{6'd3, 6'd0, 6'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0,
                   32'h55, 32'h0, 32'h0, 3'b000, 1'b1, 6'd0};
        vt[5]  = '{6'd0, 6'd9, 6'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h11,
                   32'h0, BYP ? 32'h11 : 32'h0, 32'h0, 3'b010, 1'b1, 6'd1};
        vt[6]  = '{6'd0, 6'd9, 6'd4, 32'h0, 1'b0, 5'd0, 1'b1, 5'd4, 32'hABCD,
                   32'h0, 32'h11, BYP ? 32'hABCD : 32'h0, 3'b010, 1'b0, 6'd1};
        vt[7]  = '{6'd0, 6'd9, 6'd4, 32'h0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h77,
                   32'h0, BYP ? 32'h77 : 32'h11, 32'hABCD, BYP ? 3'b000 : 3'b010, 1'b0, 6'd1};
        vt[8]  = '{6'd5, 6'd9, 6'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0,
                   32'h0, 32'h77, 32'h0, 3'b000, 1'b1, 6'd0};
        vt[9]  = '{6'h20, 6'd0, 6'd0, 32'hDEADBEEF, 1'b1, 5'd10, 1'b0, 5'd0, 32'h0,
                   32'hDEADBEEF, 32'h0, 32'h0, 3'b000, 1'b1, 6'd0};
        vt[10] = '{6'd10, 6'd0, 6'd0, 32'h0, 1'b1, 5'd11, 1'b1, 5'd10, 32'h1234,
                   BYP ? 32'h1234 : 32'h0, 32'h0, 32'h0, BYP ? 3'b000 : 3'b001, 1'b1, 6'd1};
        vt[11] = '{6'd10, 6'd11, 6'd9, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,
                   32'h1234, 32'h0, 32'h77, 3'b010, 1'b0, 6'd1};

        reset = 1'b1;
        drive(6'd3, 6'd5, 6'd31, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset pend_cnt", 64'(bus.pend_cnt), 64'd0);
        check("reset rd_data", 64'(bus.rd_data), 64'd0);
        check("reset rd_busy", 64'(bus.rd_busy), 64'd0);

        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            drive(vt[i].s0, vt[i].s1, vt[i].s2, vt[i].pc, vt[i].iv, vt[i].ir,
                  vt[i].wv, vt[i].wr, vt[i].wd);
            @(negedge clk);
            check($sformatf("v%0d rd_data0", i), 64'(bus.rd_data[31:0]),  64'(vt[i].e0));
            check($sformatf("v%0d rd_data1", i), 64'(bus.rd_data[63:32]), 64'(vt[i].e1));
            check($sformatf("v%0d rd_data2", i), 64'(bus.rd_data[95:64]), 64'(vt[i].e2));
            check($sformatf("v%0d rd_busy", i),  64'(bus.rd_busy),        64'(vt[i].eb));
            check($sformatf("v%0d iss_ready", i), 64'(bus.iss_ready),     64'(vt[i].er));
            check($sformatf("v%0d pend_cnt", i), 64'(bus.pend_cnt),       64'(vt[i].ep));
        end

        // Reset mid-traffic: x5 written and x7 reserved, then async reset between edges.
        @(posedge clk); #1;
        drive(6'd5, 6'd7, 6'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd5, 32'hDEAD);
        @(posedge clk); #1;
        drive(6'd5, 6'd7, 6'd11, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("pre-reset x5", 64'(bus.rd_data[31:0]), 64'hDEAD);
        check("pre-reset busy", 64'(bus.rd_busy), 64'b110);
        check("pre-reset pend", 64'(bus.pend_cnt), 64'd2);
        #1 reset = 1'b1;
        #1;
        check("async reset rd_data", 64'(bus.rd_data), 64'd0);
        check("async reset rd_busy", 64'(bus.rd_busy), 64'd0);
        check("async reset pend", 64'(bus.pend_cnt), 64'd0);
        drive(6'd5, 6'd7, 6'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd5, 32'hBEEF);
        @(posedge clk);
        @(negedge clk);
        check("reset drops wb", 64'(bus.rd_data[31:0]), 64'd0);
        check("reset drops issue", 64'(bus.pend_cnt), 64'd0);
        drive(6'd0, 6'd0, 6'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        reset = 1'b0;

        // Fill every register's reservation, then retire in reverse order.
        for (int i = 1; i < 32; i++) begin
            @(posedge clk); #1;
            drive(6'(i), 6'd0, 6'd0, 32'h0, 1'b1, 5'(i), 1'b0, 5'd0, 32'h0);
            @(negedge clk);
            check($sformatf("fill x%0d ready", i), 64'(bus.iss_ready), 64'd1);
            check($sformatf("fill x%0d pend", i), 64'(bus.pend_cnt), 64'(i - 1));
        end
        @(posedge clk); #1;
        drive(6'd20, 6'd0, 6'd0, 32'h0, 1'b1, 5'd20, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("full pend", 64'(bus.pend_cnt), 64'd31);
        check("full waw reject", 64'(bus.iss_ready), 64'd0);
        check("full x20 busy", 64'(bus.rd_busy[0]), 64'd1);
        for (int i = 31; i >= 1; i--) begin
            @(posedge clk); #1;
            drive(6'd0, 6'd0, 6'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'(i), 32'(i * 16));
            @(negedge clk);
            check($sformatf("retire x%0d pend", i), 64'(bus.pend_cnt), 64'(i));
        end
        @(posedge clk); #1;
        drive(6'd31, 6'd1, 6'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd1, 32'h999);
        @(negedge clk);
        check("drained pend", 64'(bus.pend_cnt), 64'd0);
        check("drained x31", 64'(bus.rd_data[31:0]), 64'h1F0);
        @(posedge clk); #1;
        drive(6'd31, 6'd1, 6'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("no wrap pend", 64'(bus.pend_cnt), 64'd0);
        check("non-busy wb data", 64'(bus.rd_data[63:32]), 64'h999);
        check("drained busy", 64'(bus.rd_busy), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
